controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/veririsc_pkg.sv | 27 ++
 rtl/controller.sv | 111 +++++++++++
 2 files changed

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: the opcode encoding used by both the ALU and the
// controller, and the eight-phase instruction-cycle enumeration.
package veririsc_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

endpackage

// File: rtl/controller.sv
// VeriRISC controller: eight-phase sequencer with combinational control decode.
// Define CTRL_HALT_LATCH_EN to freeze at OP_ADDR on HLT until a go strobe.
module controller
  import veririsc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
`ifdef CTRL_HALT_LATCH_EN
  input  logic                go,
`endif
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [2:0]          phase
);

  phase_t phase_q;
  phase_t phase_d;

  logic is_hlt;
  logic is_skz;
  logic is_jmp;
  logic is_sto;
  logic is_aluop;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_sto   = (opcode == OP_STO);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset forces INST_ADDR without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_t'(phase_q + 3'd1);
`ifdef CTRL_HALT_LATCH_EN
    if (phase_q == PH_OP_ADDR && is_hlt && !go) begin
      phase_d = phase_q;
    end
`endif
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (phase_q)
      PH_INST_ADDR: begin
        sel = 1'b1;
      end
      PH_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      PH_OP_FETCH: begin
        rd = is_aluop;
      end
      PH_ALU_OP: begin
        rd     = is_aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      PH_STORE: begin
        rd     = is_aluop;
        inc_pc = is_jmp;
        ld_pc  = is_jmp;
        data_e = is_sto;
        ld_ac  = is_aluop;
        wr     = is_sto;
      end
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule
